// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: the response codes and the master state encoding.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } master_state_t;

endpackage

// File: rtl/axi4_lite_master_rw.sv
// Single-outstanding AXI4-Lite master bridging a local request/response port
// onto the AW/W/B and AR/R channels, with a sticky response-wait timeout flag.
module axi4_lite_master_rw
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              USR_ENA,
  input  logic [STRB_W-1:0] USR_WSTB,
  input  logic [ADDR_W-1:0] USR_ADDR,
  input  logic [DATA_W-1:0] USR_WDATA,
  input  logic [2:0]        USR_PROT,
  output logic              USR_READY,
  output logic              USR_DONE,
  output logic [DATA_W-1:0] USR_RDATA,
  output resp_t             USR_RESP,
  output logic              USR_TIMEOUT
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axi4_lite_master_rw: DATA_W must be 32 or 64");
  end

  // A zero limit disables the timeout; keep the counter one bit wide then.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  master_state_t     state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [2:0]        prot_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              waiting;

  // Address, data and prot only change on acceptance, so they stay stable under VALID.
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWPROT    = prot_q;
  assign ARPROT    = prot_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = strb_q;
  assign USR_READY = (state == ST_IDLE);
  assign waiting   = (BREADY && !BVALID) || (RREADY && !RVALID);

  always_ff @(posedge ACLK) begin
    // NOTE: reset is sampled on the clock edge, and every register -- including the
    // datapath copies -- is cleared so the outputs are fully defined out of reset.
    if (!ARESETn) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      AWVALID     <= 1'b0;
      WVALID      <= 1'b0;
      BREADY      <= 1'b0;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      USR_DONE    <= 1'b0;
      USR_RDATA   <= '0;
      USR_RESP    <= OKAY;
      USR_TIMEOUT <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; every branch reads the pre-edge
      // values, so AW and W handshakes in the same cycle are evaluated consistently.
      USR_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (USR_ENA) begin
            addr_q  <= USR_ADDR;
            wdata_q <= USR_WDATA;
            strb_q  <= USR_WSTB;
            prot_q  <= USR_PROT;
            if (|USR_WSTB) begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= ST_WR_ADDR_DATA;
            end else begin
              ARVALID <= 1'b1;
              state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR_DATA: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          // Each channel is finished when its VALID is already low or handshakes now.
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
            BREADY   <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            BREADY   <= 1'b0;
            USR_RESP <= resp_t'(BRESP);
            USR_DONE <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (ARREADY) begin
            ARVALID  <= 1'b0;
            RREADY   <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            USR_RDATA <= RDATA;
            USR_RESP  <= resp_t'(RRESP);
            USR_DONE  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Saturating wait counter; the transaction keeps waiting after the flag is set.
      if (TIMEOUT_CYCLES != 0 && waiting && wait_cnt != TO_LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == TO_LAST) USR_TIMEOUT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// Directed bench for axi4_lite_master_rw: a transaction-level model checked every
// cycle, a configurable slave responder, and literal checks on key cycles.
module tb_axi4_lite_master_rw;
  import axi4_lite_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int TO     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic              bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]        bresp = 2'd0, rresp = 2'd0;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata = '0;
  logic              usr_ena = 1'b0;
  logic [STRB_W-1:0] usr_wstb = '0;
  logic [ADDR_W-1:0] usr_addr = '0;
  logic [DATA_W-1:0] usr_wdata = '0;
  logic [2:0]        usr_prot = '0;
  logic              usr_ready, usr_done, usr_timeout;
  logic [DATA_W-1:0] usr_rdata;
  resp_t             usr_resp;

  axi4_lite_master_rw #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
    .USR_ENA(usr_ena), .USR_WSTB(usr_wstb), .USR_ADDR(usr_addr),
    .USR_WDATA(usr_wdata), .USR_PROT(usr_prot), .USR_READY(usr_ready),
    .USR_DONE(usr_done), .USR_RDATA(usr_rdata), .USR_RESP(usr_resp),
    .USR_TIMEOUT(usr_timeout)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave responder: each READY/VALID answers after a per-test number of cycles.
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]        bresp_val = 2'd0, rresp_val = 2'd0;
  logic [DATA_W-1:0] rdata_val = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    end else begin
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      w_cnt   = wvalid  ? w_cnt + 1  : 0;
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      b_cnt   = bready  ? b_cnt + 1  : 0;
      r_cnt   = rready  ? r_cnt + 1  : 0;
      awready = awvalid && aw_cnt > aw_delay;
      wready  = wvalid  && w_cnt  > w_delay;
      arready = arvalid && ar_cnt > ar_delay;
      bvalid  = bready  && b_cnt  > b_delay;
      rvalid  = rready  && r_cnt  > r_delay;
    end
    // Junk values outside the handshake expose any capture at the wrong time.
    bresp = bvalid ? bresp_val : 2'd3;
    rresp = rvalid ? rresp_val : 2'd3;
    rdata = rvalid ? rdata_val : 32'hBAD0_BAD0;
  end

  // Transaction-level model: which handshakes are still owed and what the user side shows.
  typedef struct {
    bit                busy, awp, wp, arp, bw, rw, done, to;
    int                waits;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic [STRB_W-1:0] strb;
    logic [2:0]        prot;
    logic [1:0]        resp;
  } model_t;

  model_t m = '{default: 0};

  always @(posedge clk) begin : model
    model_t n;
    n = m;
    n.done = 1'b0;
    if (!rst_n) begin
      n = '{default: 0};
    end else if (!n.busy) begin
      if (usr_ena) begin
        n.busy = 1'b1; n.addr = usr_addr; n.wdata = usr_wdata;
        n.strb = usr_wstb; n.prot = usr_prot;
        if (usr_wstb != '0) begin n.awp = 1'b1; n.wp = 1'b1; end
        else n.arp = 1'b1;
      end
    end else if (n.awp || n.wp) begin
      if (n.awp && awready) n.awp = 1'b0;
      if (n.wp && wready)   n.wp  = 1'b0;
      if (!n.awp && !n.wp) begin n.bw = 1'b1; n.waits = 0; end
    end else if (n.arp) begin
      if (arready) begin n.arp = 1'b0; n.rw = 1'b1; n.waits = 0; end
    end else if (n.bw || n.rw) begin
      if (n.bw ? bvalid : rvalid) begin
        n.resp = n.bw ? bresp : rresp;
        if (n.rw) n.rdata = rdata;
        n.bw = 1'b0; n.rw = 1'b0; n.busy = 1'b0; n.done = 1'b1;
      end else begin
        n.waits++;
        if (n.waits >= TO) n.to = 1'b1;
      end
    end
    m <= n;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("awvalid", awvalid, m.awp);
      check("wvalid", wvalid, m.wp);
      check("arvalid", arvalid, m.arp);
      check("bready", bready, m.bw);
      check("rready", rready, m.rw);
      if (m.awp) begin check("awaddr", awaddr, m.addr); check("awprot", awprot, m.prot); end
      if (m.wp)  begin check("wdata", wdata, m.wdata); check("wstrb", wstrb, m.strb); end
      if (m.arp) begin check("araddr", araddr, m.addr); check("arprot", arprot, m.prot); end
      check("usr_ready", usr_ready, !m.busy);
      check("usr_done", usr_done, m.done);
      check("usr_resp", usr_resp, m.resp);
      check("usr_rdata", usr_rdata, m.rdata);
      check("usr_timeout", usr_timeout, m.to);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Request driven through cycle 0; returns at mid-cycle 1.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s, input logic [2:0] p);
    @(posedge clk); #1;
    usr_ena = 1'b1; usr_addr = a; usr_wdata = d; usr_wstb = s; usr_prot = p;
    @(posedge clk); #1;
    usr_ena = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (usr_done !== 1'b1 && n < max_cycles);
    check(name, usr_done, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    step();
    check("reset_ready", usr_ready, 1'b1);
    check("reset_awvalid", awvalid, 1'b0);
    check("reset_timeout", usr_timeout, 1'b0);
    check("reset_rdata", usr_rdata, 32'h0);

    // Write, slave always ready: AW/W cycle 1, BREADY cycle 2, USR_DONE cycle 3.
    issue(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000);
    check("wr_c1_awvalid", awvalid, 1'b1);
    check("wr_c1_wvalid", wvalid, 1'b1);
    check("wr_c1_awaddr", awaddr, 32'h10);
    check("wr_c1_wdata", wdata, 32'hDEAD_BEEF);
    step();
    check("wr_c2_bready", bready, 1'b1);
    check("wr_c2_awvalid", awvalid, 1'b0);
    step();
    check("wr_c3_done", usr_done, 1'b1);
    check("wr_c3_resp", usr_resp, 2'd0);

    // Read with ARREADY three cycles late: ARVALID held cycles 1..4.
    ar_delay = 3; rdata_val = 32'hCAFE_F00D; rresp_val = 2'd0;
    issue(32'h20, 32'h0, 4'h0, 3'b001);
    for (int c = 1; c <= 4; c++) begin
      check("rd_arvalid_held", arvalid, 1'b1);
      check("rd_araddr_stable", araddr, 32'h20);
      step();
    end
    check("rd_c5_arvalid", arvalid, 1'b0);
    check("rd_c5_rready", rready, 1'b1);
    wait_done(4, "rd_done");
    check("rd_rdata", usr_rdata, 32'hCAFE_F00D);
    ar_delay = 0;

    // AW at cycle 1, W at cycle 4: BREADY only from cycle 5.
    w_delay = 3;
    issue(32'h30, 32'h1234_5678, 4'b0011, 3'b010);
    check("wd_c1_awvalid", awvalid, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step();
      check("wd_awvalid_low", awvalid, 1'b0);
      check("wd_wvalid_held", wvalid, 1'b1);
      check("wd_bready_low", bready, 1'b0);
    end
    step();
    check("wd_c5_bready", bready, 1'b1);
    wait_done(4, "wd_done");
    w_delay = 0;

    // Timeout: RVALID at wait cycle 12, flag set at the end of wait cycle 8.
    r_delay = 11; rdata_val = 32'h0BAD_F00D; rresp_val = 2'd1;
    issue(32'h60, 32'h0, 4'h0, 3'b000);
    repeat (8) step();
    check("to_wc8_flag", usr_timeout, 1'b0);
    check("to_wc8_rready", rready, 1'b1);
    step();
    check("to_wc9_flag", usr_timeout, 1'b1);
    wait_done(6, "to_done");
    check("to_rdata", usr_rdata, 32'h0BAD_F00D);
    check("to_resp", usr_resp, 2'd1);
    step();
    check("to_sticky", usr_timeout, 1'b1);
    r_delay = 0;

    // Back-to-back: read then write with USR_ENA held; SLVERR on the write.
    bresp_val = 2'd2; rdata_val = 32'h55AA_55AA; rresp_val = 2'd0;
    @(posedge clk); #1;
    usr_ena = 1'b1; usr_wstb = 4'h0; usr_addr = 32'h40; usr_prot = 3'b000;
    @(posedge clk); #1;
    usr_wstb = 4'hF; usr_addr = 32'h44; usr_wdata = 32'hA5A5_A5A5; usr_prot = 3'b100;
    @(negedge clk);
    wait_done(4, "b2b_rd_done");
    check("b2b_ready_with_done", usr_ready, 1'b1);
    check("b2b_rd_rdata", usr_rdata, 32'h55AA_55AA);
    @(posedge clk); #1;
    usr_ena = 1'b0;
    @(negedge clk);
    check("b2b_wr_awvalid", awvalid, 1'b1);
    check("b2b_wr_awaddr", awaddr, 32'h44);
    wait_done(4, "b2b_wr_done");
    check("b2b_wr_resp", usr_resp, 2'd2);
    check("b2b_rdata_held", usr_rdata, 32'h55AA_55AA);
    bresp_val = 2'd0;

    // Reset while AW/W are outstanding: everything drops, no completion.
    aw_delay = 5; w_delay = 5;
    issue(32'h50, 32'h7777_7777, 4'hF, 3'b000);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_done", usr_done, 1'b0);
    check("rst_ready", usr_ready, 1'b1);
    check("rst_timeout", usr_timeout, 1'b0);
    aw_delay = 0; w_delay = 0;
    repeat (3) step();

    // Recovery read after reset.
    rdata_val = 32'h0000_0042; rresp_val = 2'd3;
    issue(32'h70, 32'h0, 4'h0, 3'b000);
    wait_done(4, "post_rst_done");
    check("post_rst_rdata", usr_rdata, 32'h42);
    check("post_rst_resp", usr_resp, 2'd3);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
